motor_drive_ctrl: RTL and testbench
===================================

# motor_drive_ctrl

Parametrised multi-channel H-bridge motor controller with per-channel duty ramping, direction-reversal dead time and stall lockout. It replaces the fixed two-motor, fixed-ratio control path. Each channel takes a speed magnitude and direction and drives one bridge (two direction pins plus one PWM enable). It sits between the command decoder and the motor driver pins.

## Interface
- CHANNELS, 2, number of independent motor channels (1..8)
- PWM_BITS, 8, PWM counter and duty width; period = 2^PWM_BITS cycles
- RAMP_DIV, 4, cycles per ramp tick; duty moves 1 LSB per tick (>=1)
- DEAD_CYCLES, 16, bridge-off cycles inserted on direction reversal (>=1)
- STALL_CYCLES, 1000, consecutive synced stall-sense cycles needed to declare a stall (>=1)

- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous assert, active-low
- cmd_speed  in  CHANNELS*PWM_BITS  target duty per channel, unsigned; channel i at [i*PWM_BITS +: PWM_BITS]
- cmd_dir  in  CHANNELS  per-channel direction, 1 = forward
- brake  in  1  global short-brake; has priority over coast
- coast  in  1  global coast
- st_pins  in  CHANNELS  raw stall sense, active-high, asynchronous
- stall_clr  in  1  single-cycle pulse; clears latched stalls
- in_a  out  CHANNELS  bridge input A (IN1/IN3 equivalent)
- in_b  out  CHANNELS  bridge input B (IN2/IN4 equivalent)
- en  out  CHANNELS  PWM enable (ENA/ENB equivalent)
- stalled  out  CHANNELS  latched stall flag per channel
- st_in  out  1  OR of stalled

## Operation
- Shared free-running PWM counter, PWM_BITS wide, wraps from 2^PWM_BITS-1 to 0. en[i] = (cnt < duty[i]), registered. duty 0 gives a constant low; duty 2^PWM_BITS-1 gives high for all but one cycle per period.
- Shared ramp prescaler produces one tick every RAMP_DIV cycles. On a tick, each channel's duty steps one LSB toward its target. No overshoot.
- Per-channel FSM has four states: IDLE, RUN, DEAD, STALL. dir_applied holds the current direction.
  - IDLE: duty 0, in_a=in_b=0. If cmd_speed != 0: dir_applied <= cmd_dir, go to RUN.
  - RUN: target = cmd_speed when cmd_dir == dir_applied, else 0. Drive in_a=dir_applied, in_b=~dir_applied. When duty==0 and target==0: go to DEAD if cmd_dir != dir_applied and cmd_speed != 0, else go to IDLE.
  - DEAD: duty 0, in_a=in_b=0 for exactly DEAD_CYCLES cycles. Then dir_applied <= cmd_dir and go to RUN.
  - STALL: duty 0, in_a=in_b=0, stalled[i]=1. Leave to IDLE only on stall_clr with the synced st_pins[i] low. stall_clr while the sense is still high is ignored.
- Stall detection:
  - st_pins passes through a 2-flop synchroniser.
  - A per-channel counter (ceil(log2(STALL_CYCLES+1)) bits, saturating) counts consecutive high cycles while in RUN. It resets when the sense goes low or the state leaves RUN.
  - Reaching STALL_CYCLES moves the channel to STALL.
- brake (any channel): forces all channels to IDLE with duty 0 and aborts DEAD. While brake is held: in_a=in_b=en=1. Stall counters hold; STALL state is retained.
- coast without brake: same forced IDLE, with in_a=in_b=en=0.
- On release of brake/coast, channels restart from IDLE and ramp from 0.

## Timing
- Reset values: in_a, in_b, en, stalled, st_in all 0; counters 0; all FSMs in IDLE; duty 0; dir_applied 1.
- en lags counter/duty by 1 cycle. in_a/in_b are registered and change in the same cycle as the state register.
- Command to first duty change: <= RAMP_DIV+1 cycles. Full-scale ramp from 0 to D takes D*RAMP_DIV cycles, ±RAMP_DIV.
- Reversal at duty D: D*RAMP_DIV ramp-down, then DEAD_CYCLES off, then ramp-up. in_a and in_b are never both 1 outside brake.
- Stall sense to stalled: 2 sync cycles + STALL_CYCLES + 1.
- brake/coast take effect on outputs 1 cycle after sampling.
- A simultaneous stall-threshold and brake resolves in favour of brake: no stall is latched.
- Asserting rst_n low mid-operation clears all outputs asynchronously.

## Test plan
- Reset release with cmd_speed=128, cmd_dir=1, defaults:
  - duty reaches 128 after 512±4 cycles.
  - en then measures 128 high of every 256 cycles.
  - in_a=1, in_b=0.
- Reversal at duty 64: toggle cmd_dir=0.
  - duty falls to 0 in 256±4 cycles.
  - Exactly 16 cycles of in_a=in_b=en=0 follow.
  - Then in_a=0, in_b=1 and the ramp restarts.
  - Check every cycle that in_a&in_b is never 1.
- In RUN, hold st_pins[0]=1 for 1000 cycles:
  - stalled[0] and st_in rise at cycle 1003.
  - Channel 0 outputs go to 0 while channel 1 is unaffected.
- Stall recovery:
  - stall_clr with the sense high: stalled stays 1.
  - Drop the sense, then pulse stall_clr: back to IDLE and ramps from 0.
  - An 800-cycle stall pulse must not latch.
- brake and coast asserted together mid-ramp:
  - brake wins: in_a=in_b=en=1 on all channels.
  - Release: duty restarts at 0.
  - coast alone gives all outputs 0.
- CHANNELS=4, PWM_BITS=10, duty targets 0 / 1023 / 1 / 512:
  - en is constant 0, high 1023/1024, high 1/1024 and high 512/1024 respectively.
  - rst_n pulsed low mid-ramp clears everything.

Source files
------------

// File: rtl/motor_drive_ctrl.sv
// Multi-channel H-bridge controller: shared PWM counter and ramp prescaler,
// per-channel duty ramping, reversal dead time and latched stall lockout.
module motor_drive_ctrl #(
    parameter int unsigned CHANNELS     = 2,
    parameter int unsigned PWM_BITS     = 8,
    parameter int unsigned RAMP_DIV     = 4,
    parameter int unsigned DEAD_CYCLES  = 16,
    parameter int unsigned STALL_CYCLES = 1000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CHANNELS*PWM_BITS-1:0] cmd_speed,
    input  logic [CHANNELS-1:0]          cmd_dir,
    input  logic                         brake,
    input  logic                         coast,
    input  logic [CHANNELS-1:0]          st_pins,
    input  logic                         stall_clr,
    output logic [CHANNELS-1:0]          in_a,
    output logic [CHANNELS-1:0]          in_b,
    output logic [CHANNELS-1:0]          en,
    output logic [CHANNELS-1:0]          stalled,
    output logic                         st_in
);

    localparam int unsigned PRESC_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int unsigned DEAD_W  = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam int unsigned STALL_W = $clog2(STALL_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DEAD  = 2'd2,
        S_STALL = 2'd3
    } state_t;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PRESC_W-1:0]  presc;
    logic                ramp_tick;
    logic [CHANNELS-1:0] sense_meta;
    logic [CHANNELS-1:0] sense_sync;
    logic [CHANNELS-1:0] stall_nxt;

    assign ramp_tick = (presc == PRESC_W'(RAMP_DIV - 1));

    // Free-running PWM counter and ramp prescaler shared by all channels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            presc   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            presc   <= ramp_tick ? '0 : presc + PRESC_W'(1);
        end
    end

    // Two-flop synchroniser for the asynchronous stall-sense pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sense_meta <= '0;
            sense_sync <= '0;
        end else begin
            sense_meta <= st_pins;
            sense_sync <= sense_meta;
        end
    end

    // Global stall indicator, aligned with the per-channel stalled flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_in <= 1'b0;
        end else begin
            st_in <= |stall_nxt;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [PWM_BITS-1:0] speed;
        logic                sense;

        state_t              state;
        state_t              state_nxt;
        logic [PWM_BITS-1:0] duty;
        logic [PWM_BITS-1:0] duty_nxt;
        logic [PWM_BITS-1:0] target;
        logic                dir_q;
        logic                dir_nxt;
        logic [DEAD_W-1:0]   dead_cnt;
        logic [DEAD_W-1:0]   dead_nxt;
        logic [STALL_W-1:0]  stall_cnt;
        logic [STALL_W-1:0]  stall_cnt_nxt;

        logic                in_a_q;
        logic                in_b_q;
        logic                en_q;
        logic                stalled_q;
        logic                in_a_nxt;
        logic                in_b_nxt;
        logic                en_nxt;

        assign speed        = cmd_speed[i*PWM_BITS +: PWM_BITS];
        assign sense        = sense_sync[i];
        assign stall_nxt[i] = (state_nxt == S_STALL);

        assign in_a[i]    = in_a_q;
        assign in_b[i]    = in_b_q;
        assign en[i]      = en_q;
        assign stalled[i] = stalled_q;

        // Next-state, duty ramp, dead-time and stall-counter logic
        always_comb begin
            state_nxt     = state;
            duty_nxt      = duty;
            dir_nxt       = dir_q;
            dead_nxt      = '0;
            stall_cnt_nxt = '0;
            target        = '0;

            case (state)
                S_IDLE: begin
                    duty_nxt = '0;
                    if (speed != '0) begin
                        dir_nxt   = cmd_dir[i];
                        state_nxt = S_RUN;
                    end
                end

                S_RUN: begin
                    // A direction mismatch ramps to zero before the bridge flips
                    target = (cmd_dir[i] == dir_q) ? speed : '0;
                    if (ramp_tick) begin
                        if (duty < target) begin
                            duty_nxt = duty + PWM_BITS'(1);
                        end else if (duty > target) begin
                            duty_nxt = duty - PWM_BITS'(1);
                        end
                    end
                    if (stall_cnt == STALL_W'(STALL_CYCLES)) begin
                        state_nxt = S_STALL;
                        duty_nxt  = '0;
                    end else if ((duty == '0) && (target == '0)) begin
                        if ((cmd_dir[i] != dir_q) && (speed != '0)) begin
                            state_nxt = S_DEAD;
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end
                end

                S_DEAD: begin
                    duty_nxt = '0;
                    dead_nxt = dead_cnt + DEAD_W'(1);
                    if (dead_cnt == DEAD_W'(DEAD_CYCLES - 1)) begin
                        dead_nxt  = '0;
                        dir_nxt   = cmd_dir[i];
                        state_nxt = S_RUN;
                    end
                end

                S_STALL: begin
                    duty_nxt = '0;
                    // Clearing is refused while the sense line is still asserted
                    if (stall_clr && !sense) begin
                        state_nxt = S_IDLE;
                    end
                end

                default: begin
                    duty_nxt  = '0;
                    state_nxt = S_IDLE;
                end
            endcase

            // Consecutive-high counter, only meaningful while driving the motor
            if ((state == S_RUN) && sense) begin
                if (stall_cnt == STALL_W'(STALL_CYCLES)) begin
                    stall_cnt_nxt = stall_cnt;
                end else begin
                    stall_cnt_nxt = stall_cnt + STALL_W'(1);
                end
            end

            // Brake/coast override everything except a latched stall
            if (brake || coast) begin
                state_nxt = (state == S_STALL) ? S_STALL : S_IDLE;
                duty_nxt  = '0;
                dead_nxt  = '0;
                dir_nxt   = dir_q;
                if (brake) begin
                    stall_cnt_nxt = stall_cnt;
                end else begin
                    stall_cnt_nxt = '0;
                end
            end
        end

        // Bridge pin values derived from the upcoming state so they switch with it
        always_comb begin
            in_a_nxt = 1'b0;
            in_b_nxt = 1'b0;
            en_nxt   = 1'b0;
            if (brake) begin
                in_a_nxt = 1'b1;
                in_b_nxt = 1'b1;
                en_nxt   = 1'b1;
            end else if (!coast) begin
                if (state_nxt == S_RUN) begin
                    in_a_nxt = dir_nxt;
                    in_b_nxt = ~dir_nxt;
                end
                en_nxt = (pwm_cnt < duty);
            end
        end

        // Channel state and registered bridge outputs
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state     <= S_IDLE;
                duty      <= '0;
                dir_q     <= 1'b1;
                dead_cnt  <= '0;
                stall_cnt <= '0;
                in_a_q    <= 1'b0;
                in_b_q    <= 1'b0;
                en_q      <= 1'b0;
                stalled_q <= 1'b0;
            end else begin
                state     <= state_nxt;
                duty      <= duty_nxt;
                dir_q     <= dir_nxt;
                dead_cnt  <= dead_nxt;
                stall_cnt <= stall_cnt_nxt;
                in_a_q    <= in_a_nxt;
                in_b_q    <= in_b_nxt;
                en_q      <= en_nxt;
                stalled_q <= (state_nxt == S_STALL);
            end
        end
    end

endmodule

// File: tb/tb_motor_drive_ctrl.sv
// Directed bench for motor_drive_ctrl: a default 2-channel instance and a
// 4-channel 10-bit instance sharing one clock.
module tb_motor_drive_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: defaults (2 channels, 8-bit PWM)
    logic        rst_a_n;
    logic [15:0] speed_a;
    logic [1:0]  dir_a;
    logic        brake_a, coast_a, clr_a;
    logic [1:0]  st_a;
    logic [1:0]  in_a_a, in_b_a, en_a, stalled_a;
    logic        st_in_a;

    // Instance B: 4 channels, 10-bit PWM
    logic        rst_b_n;
    logic [39:0] speed_b;
    logic [3:0]  dir_b;
    logic        brake_b, coast_b, clr_b;
    logic [3:0]  st_b;
    logic [3:0]  in_a_b, in_b_b, en_b, stalled_b;
    logic        st_in_b;

    int compared   = 0;
    int mismatched = 0;

    motor_drive_ctrl dut_a (
        .clk(clk), .rst_n(rst_a_n), .cmd_speed(speed_a), .cmd_dir(dir_a),
        .brake(brake_a), .coast(coast_a), .st_pins(st_a), .stall_clr(clr_a),
        .in_a(in_a_a), .in_b(in_b_a), .en(en_a), .stalled(stalled_a), .st_in(st_in_a)
    );

    motor_drive_ctrl #(.CHANNELS(4), .PWM_BITS(10)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .cmd_speed(speed_b), .cmd_dir(dir_b),
        .brake(brake_b), .coast(coast_b), .st_pins(st_b), .stall_clr(clr_b),
        .in_a(in_a_b), .in_b(in_b_b), .en(en_b), .stalled(stalled_b), .st_in(st_in_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
        compared++;
        assert (obs >= lo && obs <= hi) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Advance n clock edges and settle just after the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int  cyc;
        int  off;
        int  h0, h1, h2, h3;
        logic both;

        rst_a_n = 1'b0; rst_b_n = 1'b0;
        speed_a = {8'd128, 8'd128}; dir_a = 2'b11;
        brake_a = 1'b0; coast_a = 1'b0; clr_a = 1'b0; st_a = 2'b00;
        speed_b = {10'd512, 10'd1, 10'd1023, 10'd0}; dir_b = 4'hF;
        brake_b = 1'b0; coast_b = 1'b0; clr_b = 1'b0; st_b = 4'h0;
        both = 1'b0;

        // Reset values
        step(3);
        check("rst_in_a",    32'(in_a_a),    0);
        check("rst_in_b",    32'(in_b_a),    0);
        check("rst_en",      32'(en_a),      0);
        check("rst_stalled", 32'(stalled_a), 0);
        check("rst_st_in",   32'(st_in_a),   0);

        // Ramp from reset to duty 128: 128 ticks of 4 cycles
        rst_a_n = 1'b1;
        cyc = 0;
        while (dut_a.g_ch[0].duty != 8'd128 && cyc < 2000) begin
            step(1);
            cyc++;
        end
        check_rng("ramp_up_128", cyc, 508, 516);
        check("run_in_a0", 32'(in_a_a[0]), 1);
        check("run_in_b0", 32'(in_b_a[0]), 0);
        h0 = 0; h1 = 0;
        for (int k = 0; k < 256; k++) begin
            step(1);
            h0 += int'(en_a[0]);
            h1 += int'(en_a[1]);
        end
        check("en_ch0_128", 32'(h0), 128);
        check("en_ch1_128", 32'(h1), 128);

        // Settle at duty 64, then reverse channel 0
        speed_a[7:0] = 8'd64;
        cyc = 0;
        while (dut_a.g_ch[0].duty != 8'd64 && cyc < 1000) begin
            step(1);
            cyc++;
        end
        check_rng("ramp_down_64", cyc, 252, 260);
        dir_a[0] = 1'b0;
        cyc = 0;
        while (dut_a.g_ch[0].duty != 8'd0 && cyc < 1000) begin
            step(1);
            cyc++;
            both |= in_a_a[0] & in_b_a[0];
        end
        check_rng("rev_ramp_down", cyc, 252, 260);
        cyc = 0;
        while (!(in_a_a[0] == 1'b0 && in_b_a[0] == 1'b0 && en_a[0] == 1'b0) && cyc < 50) begin
            step(1);
            cyc++;
            both |= in_a_a[0] & in_b_a[0];
        end
        off = 0;
        while (in_a_a[0] == 1'b0 && in_b_a[0] == 1'b0 && en_a[0] == 1'b0 && off < 100) begin
            off++;
            step(1);
            both |= in_a_a[0] & in_b_a[0];
        end
        check("dead_cycles", 32'(off), 16);
        check("rev_in_a0", 32'(in_a_a[0]), 0);
        check("rev_in_b0", 32'(in_b_a[0]), 1);
        for (int k = 0; k < 20; k++) begin
            step(1);
            both |= in_a_a[0] & in_b_a[0];
        end
        check_rng("rev_ramp_restart", int'(dut_a.g_ch[0].duty), 4, 6);
        check("no_shoot_through", 32'(both), 0);

        // Stall on channel 0 while running
        st_a[0] = 1'b1;
        step(1002);
        check("stall_early", 32'(stalled_a[0]), 0);
        step(1);
        check("stall_latched", 32'(stalled_a[0]), 1);
        check("stall_st_in",   32'(st_in_a),      1);
        check("stall_in_a0",   32'(in_a_a[0]),    0);
        check("stall_in_b0",   32'(in_b_a[0]),    0);
        step(1);
        check("stall_en0",     32'(en_a[0]),      0);
        check("ch1_in_a",      32'(in_a_a[1]),    1);
        check("ch1_not_stall", 32'(stalled_a[1]), 0);
        h1 = 0;
        for (int k = 0; k < 256; k++) begin
            step(1);
            h1 += int'(en_a[1]);
        end
        check("ch1_en_128", 32'(h1), 128);

        // Clear refused while the sense is high
        clr_a = 1'b1; step(1); clr_a = 1'b0;
        step(1);
        check("clr_ignored", 32'(stalled_a[0]), 1);

        // Drop the sense and clear: back through IDLE, ramping from 0
        st_a[0] = 1'b0;
        step(4);
        clr_a = 1'b1; step(1); clr_a = 1'b0;
        check("clr_stalled", 32'(stalled_a[0]), 0);
        check("clr_st_in",   32'(st_in_a),      0);
        step(1);
        check("recover_in_a0", 32'(in_a_a[0]), 0);
        check("recover_in_b0", 32'(in_b_a[0]), 1);
        check("recover_duty0", 32'(dut_a.g_ch[0].duty), 0);
        cyc = 0;
        while (dut_a.g_ch[0].duty != 8'd64 && cyc < 1000) begin
            step(1);
            cyc++;
        end
        check_rng("recover_ramp", cyc, 252, 260);

        // 800-cycle stall pulse stays below threshold
        st_a[0] = 1'b1;
        step(800);
        st_a[0] = 1'b0;
        step(20);
        check("short_stall", 32'(stalled_a[0]), 0);

        // Brake and coast together mid-ramp: brake wins
        speed_a[7:0] = 8'd200;
        step(100);
        brake_a = 1'b1; coast_a = 1'b1;
        step(1);
        check("brake_in_a", 32'(in_a_a), 3);
        check("brake_in_b", 32'(in_b_a), 3);
        check("brake_en",   32'(en_a),   3);
        step(10);
        check("brake_hold_en", 32'(en_a), 3);
        check("brake_duty0",   32'(dut_a.g_ch[0].duty), 0);
        brake_a = 1'b0; coast_a = 1'b0;
        step(1);
        check("release_duty0", 32'(dut_a.g_ch[0].duty), 0);
        check("release_en",    32'(en_a), 0);
        step(8);
        check_rng("release_ramp", int'(dut_a.g_ch[0].duty), 1, 3);

        // Coast alone
        step(40);
        coast_a = 1'b1;
        step(1);
        check("coast_in_a", 32'(in_a_a), 0);
        check("coast_in_b", 32'(in_b_a), 0);
        check("coast_en",   32'(en_a),   0);
        coast_a = 1'b0;

        // Wide instance: targets 0 / 1023 / 1 / 512
        rst_b_n = 1'b1;
        step(4200);
        h0 = 0; h1 = 0; h2 = 0; h3 = 0;
        for (int k = 0; k < 1024; k++) begin
            step(1);
            h0 += int'(en_b[0]);
            h1 += int'(en_b[1]);
            h2 += int'(en_b[2]);
            h3 += int'(en_b[3]);
        end
        check("b_en_0",    32'(h0), 0);
        check("b_en_1023", 32'(h1), 1023);
        check("b_en_1",    32'(h2), 1);
        check("b_en_512",  32'(h3), 512);
        check("b_in_a",    32'(in_a_b), 14);

        // Asynchronous reset mid-ramp
        rst_b_n = 1'b0; step(2);
        rst_b_n = 1'b1;
        step(300);
        check("b_pre_rst_in_a", 32'(in_a_b), 14);
        #2 rst_b_n = 1'b0;
        #1;
        check("b_arst_in_a",    32'(in_a_b),    0);
        check("b_arst_in_b",    32'(in_b_b),    0);
        check("b_arst_en",      32'(en_b),      0);
        check("b_arst_stalled", 32'(stalled_b), 0);
        check("b_arst_st_in",   32'(st_in_b),   0);
        check("b_arst_duty",    32'(dut_b.g_ch[3].duty), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
